// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helper for the iterative divider.
package div_pkg;

    localparam int unsigned RegBus = 32;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement negate when en is set; also serves as abs() on sign.
    function automatic logic [RegBus-1:0] cond_neg(input logic en, input logic [RegBus-1:0] v);
        return en ? (~v + RegBus'(1)) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// EX-side request/result bundle for the divider.
interface div_if
    import div_pkg::*;
();

    logic                  signed_div_i;
    logic [RegBus-1:0]     opdata1_i;
    logic [RegBus-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*RegBus-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: 33-bit trial subtract and resulting quotient bit.
module div_step
    import div_pkg::*;
(
    input  logic [RegBus:0]   rem,
    input  logic [RegBus-1:0] divisor,
    output logic [RegBus-1:0] rem_next,
    output logic              q_bit
);

    // A kept remainder is always below the divisor, so 32 bits suffice.
    assign q_bit    = (rem >= {1'b0, divisor});
    assign rem_next = q_bit ? RegBus'(rem - {1'b0, divisor}) : rem[RegBus-1:0];

endmodule

// File: rtl/div.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, 32 steps.
module div
    import div_pkg::*;
(
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);

    div_state_e           state, state_n;
    logic [5:0]           cnt, cnt_n;
    logic [2*RegBus:0]    work, work_n;
    logic [RegBus-1:0]    divisor, divisor_n;
    logic                 q_neg, q_neg_n;
    logic                 r_neg, r_neg_n;
    logic [2*RegBus-1:0]  result_n;
    logic                 ready_n;

    logic [RegBus-1:0]    step_rem;
    logic                 step_q;
    logic [2*RegBus:0]    step_work;

    // work holds the pre-shifted form: [64:32] is the next trial remainder,
    // dividend bits feed up from [31:1], quotient bits enter at [0].
    div_step u_step (
        .rem      (work[2*RegBus:RegBus]),
        .divisor  (divisor),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign step_work = {step_rem, work[RegBus-1:0], step_q};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        q_neg_n   = q_neg;
        r_neg_n   = r_neg;
        result_n  = bus.result_o;
        ready_n   = bus.ready_o;

        if (bus.annul_i) begin
            state_n  = DivFree;
            cnt_n    = '0;
            result_n = '0;
            ready_n  = DivResultNotReady;
        end else begin
            unique case (state)
                DivFree: begin
                    result_n = '0;
                    ready_n  = DivResultNotReady;
                    if (bus.start_i == DivStart) begin
                        cnt_n = '0;
                        if (bus.opdata2_i == '0) begin
                            state_n = DivByZero;
                            work_n  = {{RegBus{1'b0}}, bus.opdata1_i, 1'b0};
                        end else begin
                            state_n   = DivOn;
                            work_n    = {{RegBus{1'b0}},
                                         cond_neg(bus.signed_div_i & bus.opdata1_i[RegBus-1], bus.opdata1_i),
                                         1'b0};
                            divisor_n = cond_neg(bus.signed_div_i & bus.opdata2_i[RegBus-1], bus.opdata2_i);
                            q_neg_n   = bus.signed_div_i & (bus.opdata1_i[RegBus-1] ^ bus.opdata2_i[RegBus-1]);
                            r_neg_n   = bus.signed_div_i & bus.opdata1_i[RegBus-1];
                        end
                    end
                end
                DivByZero: begin
                    state_n  = DivEnd;
                    result_n = {work[RegBus:1], {RegBus{1'b1}}};
                    ready_n  = DivResultReady;
                end
                DivOn: begin
                    work_n = step_work;
                    cnt_n  = cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state_n  = DivEnd;
                        result_n = {cond_neg(r_neg, step_work[2*RegBus:RegBus+1]),
                                    cond_neg(q_neg, step_work[RegBus-1:0])};
                        ready_n  = DivResultReady;
                    end
                end
                DivEnd: begin
                    if (bus.start_i == DivStop) begin
                        state_n  = DivFree;
                        result_n = '0;
                        ready_n  = DivResultNotReady;
                    end
                end
                default: state_n = DivFree;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DivFree;
            cnt          <= '0;
            work         <= '0;
            divisor      <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= DivResultNotReady;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            work         <= work_n;
            divisor      <= divisor_n;
            q_neg        <= q_neg_n;
            r_neg        <= r_neg_n;
            bus.result_o <= result_n;
            bus.ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the iterative divider.
module tb_div;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    div_if bus ();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division, wait bounded for ready, check latency/result, hold, release.
    task automatic run_div(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input int exp_lat, input int hold, input logic scramble);
        int lat;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        tick();
        if (scramble) begin
            bus.opdata1_i    = ~a;
            bus.opdata2_i    = b + 32'd3;
            bus.signed_div_i = ~sgn;
        end
        lat = 0;
        while (bus.ready_o !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, bus.result_o, {er, eq});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
            chk({tag, " hold result"}, bus.result_o, {er, eq});
        end
        bus.start_i = 1'b0;
        #1;
        chk({tag, " ready before edge"}, 64'(bus.ready_o), 64'd1);
        tick();
        chk({tag, " ready drop"}, 64'(bus.ready_o), 64'd0);
        chk({tag, " result clear"}, bus.result_o, 64'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        tick();
        tick();
        chk("reset ready", 64'(bus.ready_o), 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        rst = 1'b0;
        tick();

        run_div("udiv 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32, 3, 1'b0);
        run_div("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32, 0, 1'b0);
        run_div("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32, 0, 1'b0);
        run_div("sdiv by zero", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 0, 1'b0);
        run_div("udiv by zero", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 0, 1'b0);
        run_div("sdiv overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32, 0, 1'b0);
        run_div("udiv big/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32, 0, 1'b0);

        // Abort at cnt=10 with start still high: annul must win.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd33;
        bus.start_i      = 1'b1;
        tick();
        repeat (10) tick();
        bus.annul_i = 1'b1;
        tick();
        chk("annul ready", 64'(bus.ready_o), 64'd0);
        chk("annul result", bus.result_o, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        tick();
        chk("annul idle ready", 64'(bus.ready_o), 64'd0);
        run_div("after annul", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 32, 0, 1'b0);

        // Same abort point, using reset.
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'hFFFF_FF00;
        bus.opdata2_i    = 32'd5;
        bus.start_i      = 1'b1;
        tick();
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("rst mid ready", 64'(bus.ready_o), 64'd0);
        chk("rst mid result", bus.result_o, 64'd0);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        tick();
        run_div("after rst", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 32, 0, 1'b0);

        run_div("operand change", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 32, 0, 1'b1);
        run_div("back to back", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
